// File: rtl/prog_sequencer.sv
// Run controller for the single-cycle CPU: steps a series of programs through
// the PC (load base, hold, run until Halt or timeout) and reports completion.
module prog_sequencer #(
  parameter int                PC_W       = 11,
  parameter int                NUM_PROGS  = 3,
  parameter logic [PC_W-1:0]   PROG_BASE0 = 11'd0,
  parameter logic [PC_W-1:0]   PROG_BASE1 = 11'd256,
  parameter logic [PC_W-1:0]   PROG_BASE2 = 11'd512,
  parameter logic [PC_W-1:0]   PROG_BASE3 = 11'd768,
  parameter int                HOLD_CYC   = 2,
  parameter int                CNT_W      = 16,
  parameter logic [CNT_W-1:0]  TIMEOUT    = 16'd50000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Halt,
  output logic             Start,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadAddr,
  output logic [1:0]       ProgIdx,
  output logic             Busy,
  output logic             Done,
  output logic             AllDone,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HOLD    = 3'd2,
    S_RUN     = 3'd3,
    S_FINISH  = 3'd4,
    S_ALLDONE = 3'd5
  } state_t;

  localparam int              HOLD_W       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [1:0]      LAST_IDX     = 2'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          idx_q, idx_d;
  logic [PC_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                start_q, start_d;
  logic                pcload_q, pcload_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                alldone_q, alldone_d;

  function automatic logic [PC_W-1:0] base_of(input logic [1:0] idx);
    case (idx)
      2'd0:    base_of = PROG_BASE0;
      2'd1:    base_of = PROG_BASE1;
      2'd2:    base_of = PROG_BASE2;
      2'd3:    base_of = PROG_BASE3;
      default: base_of = PROG_BASE0;
    endcase
  endfunction

  // Next-state logic; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (Go) state_d = S_LOAD;
        else    state_d = S_IDLE;
      end
      S_LOAD: begin
        hold_d  = {HOLD_W{1'b0}};
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (Halt) begin
          state_d = S_FINISH;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FINISH: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_ALLDONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_ALLDONE: begin
        if (Go) begin
          idx_d     = 2'd0;
          timeout_d = 1'b0;
          state_d   = S_LOAD;
        end else begin
          state_d = S_ALLDONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering LOAD picks the new base and clears the cycle counter.
    if (state_d == S_LOAD) begin
      cnt_d  = {CNT_W{1'b0}};
      addr_d = base_of(idx_d);
    end else begin
      addr_d = addr_q;
    end
    pcload_d  = (state_d == S_LOAD);
    start_d   = (state_d != S_RUN);
    busy_d    = (state_d == S_LOAD) || (state_d == S_HOLD) ||
                (state_d == S_RUN)  || (state_d == S_FINISH);
    done_d    = (state_d == S_FINISH);
    alldone_d = (state_d == S_ALLDONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      hold_q    <= {HOLD_W{1'b0}};
      idx_q     <= 2'd0;
      addr_q    <= PROG_BASE0;
      cnt_q     <= {CNT_W{1'b0}};
      timeout_q <= 1'b0;
      start_q   <= 1'b1;
      pcload_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alldone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      pcload_q  <= pcload_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alldone_q <= alldone_d;
    end
  end

  assign Start      = start_q;
  assign PcLoad     = pcload_q;
  assign PcLoadAddr = addr_q;
  assign ProgIdx    = idx_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign AllDone    = alldone_q;
  assign CycleCount = cnt_q;
  assign Timeout    = timeout_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer; expectations come from a
// program-level model (base = 256*idx, cycles = min(halt delay, timeout)).
module tb_prog_sequencer;

  localparam int NUM_PROGS = 3;
  localparam int HOLD_CYC  = 2;
  localparam int TMO       = 20;

  logic        Clk = 1'b0;
  logic        Reset, Go, Halt;
  logic        Start, PcLoad, Busy, Done, AllDone, Timeout;
  logic [10:0] PcLoadAddr;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic exp_tmo  = 1'b0;

  prog_sequencer #(
    .NUM_PROGS (NUM_PROGS),
    .HOLD_CYC  (HOLD_CYC),
    .TIMEOUT   (16'd20)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Go         (Go),
    .Halt       (Halt),
    .Start      (Start),
    .PcLoad     (PcLoad),
    .PcLoadAddr (PcLoadAddr),
    .ProgIdx    (ProgIdx),
    .Busy       (Busy),
    .Done       (Done),
    .AllDone    (AllDone),
    .CycleCount (CycleCount),
    .Timeout    (Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one posedge; return at the following negedge where outputs are stable.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  function automatic int base_of(input int i);
    return i * 256;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_start"},   int'(Start), 1);
    check_eq({tag, "_pcload"},  int'(PcLoad), 0);
    check_eq({tag, "_addr"},    int'(PcLoadAddr), 0);
    check_eq({tag, "_idx"},     int'(ProgIdx), 0);
    check_eq({tag, "_busy"},    int'(Busy), 0);
    check_eq({tag, "_done"},    int'(Done), 0);
    check_eq({tag, "_alldone"}, int'(AllDone), 0);
    check_eq({tag, "_count"},   int'(CycleCount), 0);
    check_eq({tag, "_timeout"}, int'(Timeout), 0);
  endtask

  task automatic check_load(input int i);
    check_eq("load_pcload",  int'(PcLoad), 1);
    check_eq("load_start",   int'(Start), 1);
    check_eq("load_addr",    int'(PcLoadAddr), base_of(i));
    check_eq("load_idx",     int'(ProgIdx), i);
    check_eq("load_busy",    int'(Busy), 1);
    check_eq("load_count",   int'(CycleCount), 0);
    check_eq("load_done",    int'(Done), 0);
    check_eq("load_alldone", int'(AllDone), 0);
    check_eq("load_timeout", int'(Timeout), int'(exp_tmo));
  endtask

  // Starts in the LOAD cycle of program i; halts k cycles after Start falls
  // (k > TMO means never halt). Ends in the next LOAD or ALLDONE cycle.
  task automatic run_prog(input int i, input int k);
    int n;
    n = (k <= TMO) ? k : TMO;
    for (int h = 0; h < HOLD_CYC; h++) begin
      Go   = 1'($urandom_range(0, 1));
      Halt = 1'($urandom_range(0, 1));
      tick();
      check_eq("hold_start",  int'(Start), 1);
      check_eq("hold_pcload", int'(PcLoad), 0);
    end
    Go   = 1'($urandom_range(0, 1));
    Halt = 1'b0;
    tick();
    check_eq("run_start", int'(Start), 0);
    check_eq("run_count", int'(CycleCount), 0);
    for (int j = 1; j < n; j++) begin
      Go = 1'($urandom_range(0, 1));
      tick();
      check_eq("run_count", int'(CycleCount), j);
      check_eq("run_done",  int'(Done), 0);
    end
    Halt = (k <= TMO);
    tick();
    if (k > TMO) exp_tmo = 1'b1;
    check_eq("fin_done",    int'(Done), 1);
    check_eq("fin_count",   int'(CycleCount), n);
    check_eq("fin_timeout", int'(Timeout), int'(exp_tmo));
    check_eq("fin_start",   int'(Start), 1);
    check_eq("fin_idx",     int'(ProgIdx), i);
    Go   = 1'($urandom_range(0, 1));
    Halt = 1'($urandom_range(0, 1));
    tick();
    Go   = 1'b0;
    Halt = 1'b0;
    if (i == NUM_PROGS - 1) begin
      check_eq("all_alldone", int'(AllDone), 1);
      check_eq("all_busy",    int'(Busy), 0);
      check_eq("all_done",    int'(Done), 0);
      check_eq("all_start",   int'(Start), 1);
      check_eq("all_idx",     int'(ProgIdx), i);
      check_eq("all_count",   int'(CycleCount), n);
      check_eq("all_timeout", int'(Timeout), int'(exp_tmo));
    end else begin
      check_load(i + 1);
    end
  endtask

  task automatic run_series(input int k0, input int k1, input int k2);
    int ks[3];
    ks[0] = k0;
    ks[1] = k1;
    ks[2] = k2;
    exp_tmo = 1'b0;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    check_load(0);
    for (int i = 0; i < NUM_PROGS; i++) run_prog(i, ks[i]);
    repeat ($urandom_range(0, 3)) begin
      tick();
      check_eq("all_wait", int'(AllDone), 1);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Go    = 1'b0;
    Halt  = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    Reset = 1'b0;
    tick();
    check_idle("idle");

    run_series(10, 10, 10);
    run_series(5, 5, 5);
    run_series(TMO + 7, 3, 4);
    run_series(TMO, TMO, 1);
    run_series(1, 1, 1);
    repeat (6) begin
      run_series(int'($urandom_range(1, TMO + 3)), int'($urandom_range(1, TMO + 3)),
                 int'($urandom_range(1, TMO + 3)));
    end

    // Reset in the middle of program 1's RUN phase.
    exp_tmo = 1'b0;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    check_load(0);
    run_prog(0, 4);
    repeat (HOLD_CYC + 3) tick();
    check_eq("pre_reset_start", int'(Start), 0);
    Reset = 1'b1;
    Go    = 1'b1;
    Halt  = 1'b1;
    tick();
    check_idle("reset_run");
    tick();
    check_idle("reset_held");
    Reset = 1'b0;
    Go    = 1'b0;
    Halt  = 1'b0;
    tick();
    check_idle("post_reset");
    run_series(2, 3, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
